// File: rtl/uart_block_link_if.sv
// Block/result handshake bundle between the serial link and a cipher core.
// Link side drives key/data/mode/blk_valid and res_ready; core side drives the rest.
interface uart_block_link_if #(
    parameter int BLOCK_BYTES = 8
) ();
    logic [8*BLOCK_BYTES-1:0] key_out;
    logic [8*BLOCK_BYTES-1:0] data_out;
    logic                     mode_out;
    logic                     blk_valid;
    logic                     blk_ready;
    logic [8*BLOCK_BYTES-1:0] res_in;
    logic                     res_valid;
    logic                     res_ready;

    modport master (
        output key_out, data_out, mode_out, blk_valid, res_ready,
        input  blk_ready, res_in, res_valid
    );

    modport slave (
        input  key_out, data_out, mode_out, blk_valid, res_ready,
        output blk_ready, res_in, res_valid
    );
endinterface

// File: rtl/uart_block_link.sv
// 8N1 UART command front end: assembles K/E/D packets into {key, data, mode} blocks and serialises results.
// Block valid one cycle after the last stop-bit sample; blk_valid holds until taken, K commits defer behind it.
module uart_block_link #(
    parameter int CLK_FREQ     = 50,
    parameter int BAUD         = 10,
    parameter int BLOCK_BYTES  = 8,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              uart_tx,
    uart_block_link_if.master cif,
    output logic              key_loaded,
    output logic              rx_busy,
    output logic              tx_busy,
    output logic              err_pulse
);
    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int W      = 8 * BLOCK_BYTES;
    localparam int CW     = $clog2(CPB + 1);
    localparam int TO_CYC = TIMEOUT_BITS * CPB;
    localparam int TW     = $clog2(TO_CYC + 1);
    localparam int BW     = $clog2(BLOCK_BYTES + 1);

    localparam logic [7:0] CMD_K = 8'h4B;
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_D = 8'h44;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [1:0] {P_CMD, P_PAYLOAD, P_DONE} pkt_state_e;

    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_e       rx_st_q, rx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            byte_vld, frame_err;

    pkt_state_e      pk_st_q, pk_st_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [W-1:0]    stage_q, stage_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic [W-1:0]    key_q, key_d, data_q, data_d, dfk_q, dfk_d;
    logic            mode_q, mode_d, bv_q, bv_d, kl_q, kl_d, dfv_q, dfv_d, err_q, err_d;
    logic            hs;

    logic            tx_busy_q, tx_busy_d, res_rdy_q, res_rdy_d, tx_q, tx_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [BW-1:0]   tx_byte_q, tx_byte_d;
    logic [W-1:0]    tx_buf_q, tx_buf_d;
    logic [7:0]      tx_cur;

    assign tx_cur = tx_buf_q[W-1 -: 8];
    assign hs     = bv_q && cif.blk_ready;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        pk_st_d   = pk_st_q;
        cmd_d     = cmd_q;
        stage_d   = stage_q;
        bcnt_d    = bcnt_q;
        tmo_d     = tmo_q;
        key_d     = key_q;
        data_d    = data_q;
        mode_d    = mode_q;
        kl_d      = kl_q;
        dfv_d     = dfv_q;
        dfk_d     = dfk_q;
        err_d     = 1'b0;
        bv_d      = bv_q && !hs;
        tx_busy_d = tx_busy_q;
        res_rdy_d = res_rdy_q;
        tx_d      = tx_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_byte_d = tx_byte_q;
        tx_buf_d  = tx_buf_q;

        // RX bit engine: every sample point is a whole number of clocks after the start-bit midpoint
        case (rx_st_q)
            R_IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_st_d  = R_START;
                    rx_cnt_d = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == CW'(CPB / 2 - 1)) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
                    else                  rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == CW'(CPB - 1)) begin
                    rx_st_d   = R_IDLE;
                    byte_vld  = rx_s2_q;
                    frame_err = !rx_s2_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
        endcase

        if (hs && dfv_q) begin
            key_d = dfk_q;
            dfv_d = 1'b0;
        end

        if (frame_err) begin
            err_d   = 1'b1;
            pk_st_d = P_CMD;
            stage_d = '0;
        end else begin
            case (pk_st_q)
                P_CMD: begin
                    if (byte_vld) begin
                        if (rx_sh_q == CMD_K || rx_sh_q == CMD_E || rx_sh_q == CMD_D) begin
                            cmd_d   = rx_sh_q;
                            pk_st_d = P_PAYLOAD;
                            bcnt_d  = '0;
                            tmo_d   = '0;
                            stage_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                P_PAYLOAD: begin
                    if (byte_vld) begin
                        stage_d = {stage_q[W-9:0], rx_sh_q};
                        tmo_d   = '0;
                        if (bcnt_q == BW'(BLOCK_BYTES - 1)) pk_st_d = P_DONE;
                        else                                bcnt_d  = bcnt_q + 1'b1;
                    end else if (rx_st_q != R_IDLE) begin
                        tmo_d = '0;
                    end else if (tmo_q == TW'(TO_CYC - 1)) begin
                        err_d   = 1'b1;
                        pk_st_d = P_CMD;
                        stage_d = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    pk_st_d = P_CMD;
                    if (cmd_q == CMD_K) begin
                        // A key landing on the handshake cycle is newer than any deferred one
                        if (!bv_q || hs) begin
                            key_d = stage_q;
                            kl_d  = 1'b1;
                            dfv_d = 1'b0;
                        end else begin
                            dfk_d = stage_q;
                            dfv_d = 1'b1;
                        end
                    end else if (!kl_q || bv_q) begin
                        err_d = 1'b1;
                    end else begin
                        data_d = stage_q;
                        mode_d = (cmd_q == CMD_D);
                        bv_d   = 1'b1;
                    end
                end
            endcase
        end

        if (!tx_busy_q) begin
            res_rdy_d = 1'b1;
            if (cif.res_valid && res_rdy_q) begin
                tx_busy_d = 1'b1;
                res_rdy_d = 1'b0;
                tx_buf_d  = cif.res_in;
                tx_cnt_d  = '0;
                tx_bit_d  = '0;
                tx_byte_d = '0;
                tx_d      = 1'b0;
            end
        end else if (tx_cnt_q == CW'(CPB - 1)) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                if (tx_byte_q == BW'(BLOCK_BYTES - 1)) begin
                    tx_busy_d = 1'b0;
                    res_rdy_d = 1'b1;
                    tx_d      = 1'b1;
                end else begin
                    tx_byte_d = tx_byte_q + 1'b1;
                    tx_bit_d  = '0;
                    tx_buf_d  = tx_buf_q << 8;
                    tx_d      = 1'b0;
                end
            end else begin
                tx_bit_d = tx_bit_q + 1'b1;
                tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_cur[tx_bit_q[2:0]];
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= R_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            pk_st_q   <= P_CMD;
            cmd_q     <= '0;
            stage_q   <= '0;
            bcnt_q    <= '0;
            tmo_q     <= '0;
            key_q     <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            bv_q      <= 1'b0;
            kl_q      <= 1'b0;
            dfv_q     <= 1'b0;
            dfk_q     <= '0;
            err_q     <= 1'b0;
            tx_busy_q <= 1'b0;
            res_rdy_q <= 1'b0;
            tx_q      <= 1'b1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_byte_q <= '0;
            tx_buf_q  <= '0;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            pk_st_q   <= pk_st_d;
            cmd_q     <= cmd_d;
            stage_q   <= stage_d;
            bcnt_q    <= bcnt_d;
            tmo_q     <= tmo_d;
            key_q     <= key_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            bv_q      <= bv_d;
            kl_q      <= kl_d;
            dfv_q     <= dfv_d;
            dfk_q     <= dfk_d;
            err_q     <= err_d;
            tx_busy_q <= tx_busy_d;
            res_rdy_q <= res_rdy_d;
            tx_q      <= tx_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_byte_q <= tx_byte_d;
            tx_buf_q  <= tx_buf_d;
        end
    end

    assign cif.key_out   = key_q;
    assign cif.data_out  = data_q;
    assign cif.mode_out  = mode_q;
    assign cif.blk_valid = bv_q;
    assign cif.res_ready = res_rdy_q;
    assign uart_tx       = tx_q;
    assign key_loaded    = kl_q;
    assign rx_busy       = (pk_st_q != P_CMD);
    assign tx_busy       = tx_busy_q;
    assign err_pulse     = err_q;
endmodule

// File: tb/tb_uart_block_link.sv
// Directed + randomised bench for uart_block_link with 8-byte and 16-byte instances.
// Expected blocks, error counts and TX bytes come from a packet-level model kept here.
module tb_uart_block_link;
    localparam int CPB = 5;

    typedef struct packed {
        logic         mode;
        logic [127:0] key;
        logic [127:0] data;
    } blk_t;

    logic clk = 1'b0;
    logic rst_n;
    logic line;
    logic sel16;
    logic rx8, rx16, tx8, tx16;
    logic kl8, rb8, tb8, err8, kl16, rb16, tb16, err16;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rx8  = sel16 ? 1'b1 : line;
    assign rx16 = sel16 ? line : 1'b1;

    uart_block_link_if #(.BLOCK_BYTES(8))  if8  ();
    uart_block_link_if #(.BLOCK_BYTES(16)) if16 ();

    uart_block_link #(.CLK_FREQ(50), .BAUD(10), .BLOCK_BYTES(8), .TIMEOUT_BITS(32)) dut8 (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx8), .uart_tx(tx8), .cif(if8),
        .key_loaded(kl8), .rx_busy(rb8), .tx_busy(tb8), .err_pulse(err8)
    );

    uart_block_link #(.CLK_FREQ(50), .BAUD(10), .BLOCK_BYTES(16), .TIMEOUT_BITS(32)) dut16 (
        .clk(clk), .rst_n(rst_n), .uart_rx(rx16), .uart_tx(tx16), .cif(if16),
        .key_loaded(kl16), .rx_busy(rb16), .tx_busy(tb16), .err_pulse(err16)
    );

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        chk(tag, 257'(obs), 257'(exp));
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        chk(tag, 257'(obs), 257'(exp));
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk(tag, 257'(obs), 257'(exp));
    endtask

    // Observed handshakes, error pulses and block stability
    blk_t got8[$], exp8[$], got16[$];
    int   err_seen8 = 0;
    int   err_seen16 = 0;
    logic bv_prev8 = 1'b0;
    blk_t held8;

    always @(negedge clk) begin
        blk_t cur;
        cur = {if8.mode_out, 64'd0, if8.key_out, 64'd0, if8.data_out};
        if (err8)  err_seen8++;
        if (err16) err_seen16++;
        if (if8.blk_valid && if8.blk_ready) got8.push_back(cur);
        if (if16.blk_valid && if16.blk_ready)
            got16.push_back({if16.mode_out, if16.key_out, if16.data_out});
        if (bv_prev8 && if8.blk_valid) chk("blk_stable", cur, held8);
        bv_prev8 = if8.blk_valid;
        held8    = cur;
    end

    // Packet-level reference model for the 8-byte instance
    logic [127:0] m_key = '0;
    logic [127:0] m_dfk = '0;
    logic         m_kl = 1'b0, m_ready = 1'b1, m_pend = 1'b0, m_dfv = 1'b0;
    blk_t         m_pend_blk;
    int           m_err = 0;

    task automatic model_pkt(input logic [7:0] cmd, input logic [127:0] pl);
        if (cmd == "K") begin
            if (m_pend) begin
                m_dfv = 1'b1;
                m_dfk = pl;
            end else begin
                m_key = pl;
                m_kl  = 1'b1;
            end
        end else if (cmd == "E" || cmd == "D") begin
            if (!m_kl || m_pend)  m_err++;
            else if (m_ready)     exp8.push_back({cmd == "D", m_key, pl});
            else begin
                m_pend     = 1'b1;
                m_pend_blk = {cmd == "D", m_key, pl};
            end
        end else begin
            m_err++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            repeat (CPB) tick();
        end
        line = stop;
        repeat (CPB) tick();
        line = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [127:0] pl, input int nb);
        send_byte(cmd, 1'b1);
        for (int i = 0; i < nb; i++) send_byte(pl[8*(nb-1-i) +: 8], 1'b1);
        repeat (12) tick();
    endtask

    task automatic pkt8(input logic [7:0] cmd, input logic [63:0] pl);
        send_pkt(cmd, {64'd0, pl}, 8);
        model_pkt(cmd, {64'd0, pl});
    endtask

    task automatic check8(input string tag);
        chki({tag, "_err"}, err_seen8, m_err);
        chki({tag, "_nblk"}, got8.size(), exp8.size());
        while (got8.size() > 0 && exp8.size() > 0) chk({tag, "_blk"}, got8.pop_front(), exp8.pop_front());
        got8.delete();
        exp8.delete();
    endtask

    task automatic tx_test(input logic [63:0] r);
        logic [79:0] bits;
        logic [7:0]  eb;
        chkb("tx_res_ready_pre", if8.res_ready, 1'b1);
        if8.res_in    = r;
        if8.res_valid = 1'b1;
        tick();
        if8.res_valid = 1'b0;
        for (int c = 0; c < 80 * CPB; c++) begin
            if (c % CPB == 2) begin
                bits[c / CPB] = tx8;
                if ((c / CPB) % 10 == 0) begin
                    chkb("tx_busy_during", tb8, 1'b1);
                    chkb("tx_res_ready_during", if8.res_ready, 1'b0);
                end
            end
            tick();
        end
        chkb("tx_busy_end", tb8, 1'b0);
        chkb("tx_res_ready_end", if8.res_ready, 1'b1);
        chkb("tx_idle_end", tx8, 1'b1);
        for (int j = 0; j < 8; j++) begin
            eb = 8'((r >> (8 * (7 - j))) & 64'hFF);
            chkb("tx_start", bits[10*j], 1'b0);
            chkw("tx_byte", {120'd0, bits[10*j+1 +: 8]}, {120'd0, eb});
            chkb("tx_stop", bits[10*j+9], 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  pl, r;
        logic [127:0] k16, d16;
        logic [7:0]   cmd;
        blk_t         b16;

        rst_n = 1'b0;
        line  = 1'b1;
        sel16 = 1'b0;
        if8.blk_ready  = 1'b1;
        if8.res_valid  = 1'b0;
        if8.res_in     = '0;
        if16.blk_ready = 1'b1;
        if16.res_valid = 1'b0;
        if16.res_in    = '0;
        repeat (3) tick();

        chkb("rst_uart_tx", tx8, 1'b1);
        chkw("rst_key", {64'd0, if8.key_out}, 128'd0);
        chkw("rst_data", {64'd0, if8.data_out}, 128'd0);
        chkb("rst_mode", if8.mode_out, 1'b0);
        chkb("rst_blk_valid", if8.blk_valid, 1'b0);
        chkb("rst_res_ready", if8.res_ready, 1'b0);
        chkb("rst_key_loaded", kl8, 1'b0);
        chkb("rst_rx_busy", rb8, 1'b0);
        chkb("rst_tx_busy", tb8, 1'b0);
        chkb("rst_err", err8, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();
        chkb("res_ready_after_rst", if8.res_ready, 1'b1);

        pkt8("E", {$urandom, $urandom});
        check8("nokey");
        chkb("nokey_bv", if8.blk_valid, 1'b0);

        send_byte(8'h55, 1'b1);
        repeat (12) tick();
        model_pkt(8'h55, '0);
        check8("badcmd");
        chkb("badcmd_rx_busy", rb8, 1'b0);

        pkt8("K", 64'h0123456789ABCDEF);
        chkb("key_loaded", kl8, 1'b1);
        pkt8("E", 64'h636F6D7075746572);
        check8("fixed");

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 2))
                0:       cmd = "K";
                1:       cmd = "E";
                default: cmd = "D";
            endcase
            pkt8(cmd, {$urandom, $urandom});
            check8("rand");
        end

        send_byte("E", 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        repeat (20) tick();
        m_err++;
        check8("frame");
        chkb("frame_rx_busy", rb8, 1'b0);
        pkt8("D", {$urandom, $urandom});
        check8("after_frame");

        send_byte("K", 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
        repeat (5) tick();
        chkb("tmo_rx_busy_pre", rb8, 1'b1);
        repeat (200) tick();
        m_err++;
        check8("timeout");
        chkb("tmo_rx_busy", rb8, 1'b0);
        chkw("tmo_key", {64'd0, if8.key_out}, m_key);

        line = 1'b0;
        repeat (2) tick();
        line = 1'b1;
        repeat (30) tick();
        check8("glitch");
        chkb("glitch_rx_busy", rb8, 1'b0);
        pkt8("E", {$urandom, $urandom});
        check8("after_glitch");

        if8.blk_ready = 1'b0;
        m_ready = 1'b0;
        pl = {$urandom, $urandom};
        pkt8("E", pl);
        check8("bp_pend");
        chkb("bp_bv", if8.blk_valid, 1'b1);
        chkw("bp_data", {64'd0, if8.data_out}, {64'd0, pl});
        pkt8("D", {$urandom, $urandom});
        check8("bp_overrun");
        chkw("bp_data_kept", {64'd0, if8.data_out}, {64'd0, pl});
        chkb("bp_mode_kept", if8.mode_out, 1'b0);
        pkt8("K", 64'h1122334455667788);
        check8("bp_key");
        chkw("bp_key_held", {64'd0, if8.key_out}, m_key);
        if8.blk_ready = 1'b1;
        m_ready = 1'b1;
        tick();
        exp8.push_back(m_pend_blk);
        m_pend = 1'b0;
        if (m_dfv) m_key = m_dfk;
        m_dfv = 1'b0;
        chkb("bp_bv_drop", if8.blk_valid, 1'b0);
        chkw("bp_key_new", {64'd0, if8.key_out}, 128'h1122334455667788);
        check8("bp_release");

        tx_test(64'h6A7D7274181D689F);
        repeat (3) tick();
        tx_test({$urandom, $urandom});

        sel16 = 1'b1;
        k16 = {$urandom, $urandom, $urandom, $urandom};
        d16 = {$urandom, $urandom, $urandom, $urandom};
        send_pkt("K", k16, 16);
        send_pkt("E", d16, 16);
        sel16 = 1'b0;
        chki("w16_nblk", got16.size(), 1);
        chki("w16_err", err_seen16, 0);
        if (got16.size() > 0) begin
            b16 = got16.pop_front();
            chk("w16_blk", b16, {1'b0, k16, d16});
        end

        if8.res_in    = {$urandom, $urandom};
        if8.res_valid = 1'b1;
        tick();
        if8.res_valid = 1'b0;
        repeat (100) tick();
        chkb("midtx_busy", tb8, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("arst_uart_tx", tx8, 1'b1);
        chkb("arst_tx_busy", tb8, 1'b0);
        chkb("arst_res_ready", if8.res_ready, 1'b0);
        chkb("arst_blk_valid", if8.blk_valid, 1'b0);
        chkw("arst_key", {64'd0, if8.key_out}, 128'd0);
        chkw("arst_data", {64'd0, if8.data_out}, 128'd0);
        chkb("arst_key_loaded", kl8, 1'b0);
        chkb("arst_rx_busy", rb8, 1'b0);
        chkb("arst_err", err8, 1'b0);
        chkb("arst_key_loaded16", kl16, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
